// File: rtl/usb_rx_pkg.sv
// Shared line-state constants, FSM state and error-code enums for the USB receive front end.
package usb_rx_pkg;

  localparam logic [1:0] LINE_X   = 2'b00;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_ILL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PAYLOAD,
    ST_EOP1,
    ST_EOP2,
    ST_ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_SYMBOL   = 2'd1,
    ERR_EOP_LEN  = 2'd2,
    ERR_CONFLICT = 2'd3
  } err_code_t;

  // SYNC is K,J alternating from index 0 and closes with a second K at the last index.
  function automatic logic [1:0] sync_sym(input int unsigned idx, input int unsigned len);
    if ((idx == len - 1) || ((idx % 2) == 0)) return LINE_K;
    return LINE_J;
  endfunction

endpackage

// File: rtl/counter.sv
// Up-counter with synchronous clear; clear takes priority over increment.
module counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/rc_dpdm_param.sv
// USB D+/D- receive front end: SYNC detect, raw bit streaming to rc_nrzi, length and EOP checks.
// state   | meaning
// IDLE    | waiting for first K of SYNC while rx_req, timeout counter running
// SYNC    | matching remaining SYNC symbols at sidx
// PAYLOAD | streaming J/K line bits, counting against latched total
// EOP1    | expecting first SE0
// EOP2    | expecting closing J
// ERROR   | sticky until abort or reset
module rc_dpdm_param
  import usb_rx_pkg::*;
#(
  parameter int DATA_BITS   = 101,
  parameter int HSHAKE_BITS = 8,
  parameter int SYNC_LEN    = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [1:0]                           bus_in,
  input  logic                                 enable,
  input  logic                                 rx_req,
  input  logic                                 rx_hs,
  input  logic                                 abort,
  output logic                                 s_out,
  output logic                                 s_valid,
  output logic                                 start_rc_nrzi,
  output logic                                 end_rc_nrzi,
  output logic                                 got_sync,
  output logic                                 rx_done,
  output logic                                 rx_timeout,
  output logic                                 err,
  output logic [1:0]                           err_code,
  output logic [$clog2(DATA_BITS+1)-1:0]       bit_count,
  output logic                                 rx_wait
);

  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam int TW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int SW  = $clog2(SYNC_LEN);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_LEN - 1);

  state_t          state_q, state_d;
  err_code_t       code_q, code_d;
  logic            err_q;
  logic [SW-1:0]   sidx_q, sidx_d;
  logic [BCW-1:0]  total_q, total_d;
  logic            hs_q, hs_d;
  logic            bc_clr, bc_inc, to_clr, to_inc;
  logic [BCW-1:0]  bc_cnt;
  logic [TW-1:0]   to_cnt;
  logic            smp_ok;

  assign smp_ok = ~enable;

  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    sidx_d        = sidx_q;
    total_d       = total_q;
    hs_d          = hs_q;
    bc_clr        = 1'b0;
    bc_inc        = 1'b0;
    to_clr        = 1'b0;
    to_inc        = 1'b0;
    s_valid       = 1'b0;
    s_out         = 1'b0;
    start_rc_nrzi = 1'b0;
    end_rc_nrzi   = 1'b0;
    got_sync      = 1'b0;
    rx_done       = 1'b0;
    rx_timeout    = 1'b0;

    // Reset is also folded in here so no pulse escapes during the reset cycle.
    if (!rst_n || abort) begin
      state_d = ST_IDLE;
      code_d  = ERR_NONE;
      sidx_d  = '0;
      bc_clr  = 1'b1;
      to_clr  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_req) begin
            to_clr = 1'b1;
          end else if (smp_ok && bus_in == LINE_K) begin
            total_d = rx_hs ? BCW'(HSHAKE_BITS) : BCW'(DATA_BITS);
            hs_d    = rx_hs;
            sidx_d  = SW'(1);
            to_clr  = 1'b1;
            state_d = ST_SYNC;
          end else if (to_cnt == TO_LAST) begin
            rx_timeout = 1'b1;
            to_clr     = 1'b1;
          end else begin
            to_inc = 1'b1;
          end
        end

        ST_SYNC: begin
          if (!smp_ok) begin
            code_d  = ERR_CONFLICT;
            state_d = ST_ERROR;
          end else if (bus_in != sync_sym(32'(sidx_q), SYNC_LEN)) begin
            sidx_d  = '0;
            state_d = ST_IDLE;
          end else if (sidx_q == SYNC_LAST) begin
            got_sync      = 1'b1;
            start_rc_nrzi = 1'b1;
            bc_clr        = 1'b1;
            sidx_d        = '0;
            state_d       = ST_PAYLOAD;
          end else begin
            sidx_d = sidx_q + SW'(1);
          end
        end

        ST_PAYLOAD: begin
          if (!smp_ok) begin
            code_d  = ERR_CONFLICT;
            state_d = ST_ERROR;
          end else if (bc_cnt < total_q) begin
            case (bus_in)
              LINE_J, LINE_K: begin
                s_valid = 1'b1;
                s_out   = (bus_in == LINE_J);
                bc_inc  = 1'b1;
              end
              LINE_X: begin
                if (hs_q) begin
                  code_d  = ERR_EOP_LEN;
                  state_d = ST_ERROR;
                end else begin
                  end_rc_nrzi = 1'b1;
                  state_d     = ST_EOP1;
                end
              end
              default: begin
                code_d  = ERR_SYMBOL;
                state_d = ST_ERROR;
              end
            endcase
          end else begin
            end_rc_nrzi = 1'b1;
            if (hs_q && bus_in == LINE_X) begin
              state_d = ST_EOP1;
            end else begin
              code_d  = ERR_EOP_LEN;
              state_d = ST_ERROR;
            end
          end
        end

        ST_EOP1: begin
          if (!smp_ok) begin
            code_d  = ERR_CONFLICT;
            state_d = ST_ERROR;
          end else if (bus_in == LINE_X) begin
            state_d = ST_EOP2;
          end else begin
            code_d  = ERR_EOP_LEN;
            state_d = ST_ERROR;
          end
        end

        ST_EOP2: begin
          if (!smp_ok) begin
            code_d  = ERR_CONFLICT;
            state_d = ST_ERROR;
          end else if (bus_in == LINE_J) begin
            rx_done = 1'b1;
            state_d = ST_IDLE;
          end else begin
            code_d  = ERR_EOP_LEN;
            state_d = ST_ERROR;
          end
        end

        ST_ERROR: state_d = ST_ERROR;

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      code_q  <= ERR_NONE;
      err_q   <= 1'b0;
      sidx_q  <= '0;
      total_q <= '0;
      hs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      err_q   <= (state_d == ST_ERROR);
      sidx_q  <= sidx_d;
      total_q <= total_d;
      hs_q    <= hs_d;
    end
  end

  counter #(.W(BCW)) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (bc_clr),
    .inc_i (bc_inc),
    .cnt_o (bc_cnt)
  );

  counter #(.W(TW)) u_to_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (to_clr),
    .inc_i (to_inc),
    .cnt_o (to_cnt)
  );

  assign bit_count = bc_cnt;
  assign err       = err_q;
  assign err_code  = code_q;
  assign rx_wait   = (state_q == ST_IDLE);

endmodule

// File: tb/tb_rc_dpdm_param.sv
// Self-checking bench for rc_dpdm_param: randomized packets against a packet-level expectation model.
module tb_rc_dpdm_param;

  localparam int DATA_BITS   = 101;
  localparam int HSHAKE_BITS = 8;
  localparam int SYNC_LEN    = 8;
  localparam int TIMEOUT_CYC = 255;
  localparam int BCW         = $clog2(DATA_BITS + 1);

  localparam logic [1:0] SYM_X = 2'b00, SYM_K = 2'b01, SYM_J = 2'b10, SYM_ILL = 2'b11;
  // Bit positions in the captured pulse vector.
  localparam int SV = 6, SO = 5, ST = 4, EN = 3, GS = 2, DN = 1, TO = 0;

  logic           clk = 1'b0;
  logic           rst_n, enable, rx_req, rx_hs, abort;
  logic [1:0]     bus_in;
  logic           s_out, s_valid, start_rc_nrzi, end_rc_nrzi, got_sync, rx_done, rx_timeout, err;
  logic [1:0]     err_code;
  logic [BCW-1:0] bit_count;
  logic           rx_wait;
  logic [6:0]     obs;
  int             checks = 0;
  int             failures = 0;

  always #5 clk = ~clk;

  rc_dpdm_param #(
    .DATA_BITS(DATA_BITS), .HSHAKE_BITS(HSHAKE_BITS), .SYNC_LEN(SYNC_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .enable(enable), .rx_req(rx_req), .rx_hs(rx_hs),
    .abort(abort), .s_out(s_out), .s_valid(s_valid), .start_rc_nrzi(start_rc_nrzi),
    .end_rc_nrzi(end_rc_nrzi), .got_sync(got_sync), .rx_done(rx_done), .rx_timeout(rx_timeout),
    .err(err), .err_code(err_code), .bit_count(bit_count), .rx_wait(rx_wait)
  );

  function automatic logic [1:0] sync_sym(input int k);
    return ((k == SYNC_LEN - 1) || (k % 2 == 0)) ? SYM_K : SYM_J;
  endfunction

  function automatic logic [1:0] rand_jk();
    return ($urandom_range(0, 1) == 1) ? SYM_J : SYM_K;
  endfunction

  // One bus cycle: apply inputs, capture combinational pulses mid-cycle, return just after the edge.
  task automatic step(input logic [1:0] b, input logic en, input logic req, input logic hs, input logic ab);
    bus_in = b; enable = en; rx_req = req; rx_hs = hs; abort = ab;
    @(negedge clk);
    obs = {s_valid, s_out, start_rc_nrzi, end_rc_nrzi, got_sync, rx_done, rx_timeout};
    @(posedge clk);
    #1;
  endtask

  task automatic idle_clear();
    step(SYM_J, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drive_prefix(input logic hs, input int n);
    idle_clear();
    for (int k = 0; k < SYNC_LEN; k++) step(sync_sym(k), 1'b0, 1'b1, hs, 1'b0);
    for (int k = 0; k < n; k++) step(rand_jk(), 1'b0, 1'b1, hs, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step(SYM_K, 1'b0, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    checks++; if (rx_wait !== 1'b1) begin failures++; $display("FAIL reset_rx_wait got=%b exp=1", rx_wait); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (err_code !== 2'd0) begin failures++; $display("FAIL reset_err_code got=%0d exp=0", err_code); end
    checks++; if (bit_count !== '0) begin failures++; $display("FAIL reset_bit_count got=%0d exp=0", bit_count); end
    step(SYM_J, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (obs !== 7'b0) begin failures++; $display("FAIL reset_pulses got=%b exp=0000000", obs); end
  endtask

  task automatic test_packet(input logic hs, input int n, input bit drop);
    logic [1:0] sq[$];
    logic       bq[$];
    logic [6:0] exp;
    logic       b;
    idle_clear();
    for (int k = 0; k < SYNC_LEN; k++) sq.push_back(sync_sym(k));
    for (int k = 0; k < n; k++) begin
      b = 1'($urandom_range(0, 1));
      bq.push_back(b);
      sq.push_back(b ? SYM_J : SYM_K);
    end
    sq.push_back(SYM_X); sq.push_back(SYM_X); sq.push_back(SYM_J);
    for (int i = 0; i < sq.size(); i++) begin
      exp = '0;
      if (i == SYNC_LEN - 1) begin exp[GS] = 1'b1; exp[ST] = 1'b1; end
      if (i >= SYNC_LEN && i < SYNC_LEN + n) begin exp[SV] = 1'b1; exp[SO] = bq[i - SYNC_LEN]; end
      if (i == SYNC_LEN + n) exp[EN] = 1'b1;
      if (i == SYNC_LEN + n + 2) exp[DN] = 1'b1;
      step(sq[i], 1'b0, (drop && i > 0) ? 1'b0 : 1'b1, (i == 0) ? hs : 1'($urandom_range(0, 1)), 1'b0);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL pkt_pulses hs=%0d n=%0d cycle=%0d got=%b exp=%b", hs, n, i, obs, exp);
      end
    end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL pkt_err hs=%0d n=%0d got=%b exp=0", hs, n, err); end
    checks++; if (rx_wait !== 1'b1) begin failures++; $display("FAIL pkt_rx_wait got=%b exp=1", rx_wait); end
    checks++;
    if (bit_count !== BCW'(n)) begin
      failures++; $display("FAIL pkt_bit_count got=%0d exp=%0d", bit_count, n);
    end
  endtask

  task automatic test_overflow();
    logic [1:0] sq[$];
    logic       bq[$];
    logic [6:0] exp;
    logic       b;
    idle_clear();
    for (int k = 0; k < SYNC_LEN; k++) sq.push_back(sync_sym(k));
    for (int k = 0; k < DATA_BITS; k++) begin
      b = 1'($urandom_range(0, 1));
      bq.push_back(b);
      sq.push_back(b ? SYM_J : SYM_K);
    end
    sq.push_back(SYM_K);
    for (int i = 0; i < sq.size(); i++) begin
      exp = '0;
      if (i == SYNC_LEN - 1) begin exp[GS] = 1'b1; exp[ST] = 1'b1; end
      if (i >= SYNC_LEN && i < SYNC_LEN + DATA_BITS) begin exp[SV] = 1'b1; exp[SO] = bq[i - SYNC_LEN]; end
      if (i == SYNC_LEN + DATA_BITS) exp[EN] = 1'b1;
      step(sq[i], 1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL ovf_pulses cycle=%0d got=%b exp=%b", i, obs, exp); end
    end
    for (int r = 0; r < 3; r++) begin
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL ovf_err_hold r=%0d got=%b exp=1", r, err); end
      checks++; if (err_code !== 2'd2) begin failures++; $display("FAIL ovf_code_hold r=%0d got=%0d exp=2", r, err_code); end
      step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      checks++; if (obs !== 7'b0) begin failures++; $display("FAIL ovf_err_pulses r=%0d got=%b exp=0000000", r, obs); end
    end
    step(SYM_J, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++; if (obs !== 7'b0) begin failures++; $display("FAIL ovf_abort_pulses got=%b exp=0000000", obs); end
    checks++; if (rx_wait !== 1'b1) begin failures++; $display("FAIL ovf_abort_idle got=%b exp=1", rx_wait); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL ovf_abort_err got=%b exp=0", err); end
    checks++; if (err_code !== 2'd0) begin failures++; $display("FAIL ovf_abort_code got=%0d exp=0", err_code); end
    checks++; if (bit_count !== '0) begin failures++; $display("FAIL ovf_abort_bc got=%0d exp=0", bit_count); end
  endtask

  task automatic test_broken_sync(input int brk);
    logic [1:0] s;
    idle_clear();
    for (int k = 0; k <= brk; k++) begin
      s = sync_sym(k);
      if (k == brk) s = (s == SYM_K) ? SYM_J : SYM_K;
      step(s, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs !== 7'b0) begin failures++; $display("FAIL brk_pulses brk=%0d k=%0d got=%b exp=0000000", brk, k, obs); end
    end
    checks++; if (rx_wait !== 1'b1) begin failures++; $display("FAIL brk_idle brk=%0d got=%b exp=1", brk, rx_wait); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL brk_err brk=%0d got=%b exp=0", brk, err); end
    test_packet(1'b1, HSHAKE_BITS, 1'b0);
  endtask

  task automatic test_timeout();
    logic [6:0] exp;
    int         pulses = 0;
    idle_clear();
    for (int c = 0; c < 2 * TIMEOUT_CYC + 10; c++) begin
      exp = '0;
      if (c % TIMEOUT_CYC == TIMEOUT_CYC - 1) exp[TO] = 1'b1;
      step(SYM_J, 1'b0, 1'b1, 1'b0, 1'b0);
      if (obs[TO]) pulses++;
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL timeout_pulse cycle=%0d got=%b exp=%b", c + 1, obs, exp); end
    end
    checks++; if (pulses != 2) begin failures++; $display("FAIL timeout_count got=%0d exp=2", pulses); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL timeout_err got=%b exp=0", err); end
  endtask

  task automatic test_conflict();
    int m = $urandom_range(1, 30);
    drive_prefix(1'b0, m);
    step(2'($urandom_range(0, 3)), 1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (obs !== 7'b0) begin failures++; $display("FAIL conf_pulses got=%b exp=0000000", obs); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL conf_err got=%b exp=1", err); end
    checks++; if (err_code !== 2'd3) begin failures++; $display("FAIL conf_code got=%0d exp=3", err_code); end
    checks++; if (bit_count !== BCW'(m)) begin failures++; $display("FAIL conf_bc got=%0d exp=%0d", bit_count, m); end
    step(SYM_J, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (err_code !== 2'd0) begin failures++; $display("FAIL conf_abort_code got=%0d exp=0", err_code); end
    checks++; if (rx_wait !== 1'b1) begin failures++; $display("FAIL conf_abort_idle got=%b exp=1", rx_wait); end
  endtask

  task automatic test_bad_symbol();
    int m = $urandom_range(0, DATA_BITS - 1);
    drive_prefix(1'b0, m);
    step(SYM_ILL, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (obs !== 7'b0) begin failures++; $display("FAIL ill_pulses got=%b exp=0000000", obs); end
    checks++; if (err_code !== 2'd1) begin failures++; $display("FAIL ill_code m=%0d got=%0d exp=1", m, err_code); end
    step(SYM_J, 1'b0, 1'b0, 1'b0, 1'b1);
    m = $urandom_range(0, HSHAKE_BITS - 1);
    drive_prefix(1'b1, m);
    step(SYM_X, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++; if (obs !== 7'b0) begin failures++; $display("FAIL hs_short_pulses got=%b exp=0000000", obs); end
    checks++; if (err_code !== 2'd2) begin failures++; $display("FAIL hs_short_code m=%0d got=%0d exp=2", m, err_code); end
    step(SYM_J, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL hs_short_abort got=%b exp=0", err); end
  endtask

  task automatic test_abort_over_done();
    drive_prefix(1'b1, HSHAKE_BITS);
    step(SYM_X, 1'b0, 1'b1, 1'b1, 1'b0);
    step(SYM_X, 1'b0, 1'b1, 1'b1, 1'b0);
    step(SYM_J, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++; if (obs !== 7'b0) begin failures++; $display("FAIL abort_done_pulses got=%b exp=0000000", obs); end
    checks++; if (rx_wait !== 1'b1) begin failures++; $display("FAIL abort_done_idle got=%b exp=1", rx_wait); end
    checks++; if (bit_count !== '0) begin failures++; $display("FAIL abort_done_bc got=%0d exp=0", bit_count); end
  endtask

  task automatic test_reset_mid();
    int m = $urandom_range(1, 60);
    drive_prefix(1'b0, m);
    step(SYM_ILL, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL rstmid_pre_err got=%b exp=1", err); end
    rst_n = 1'b0;
    step(SYM_K, 1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rstmid_err got=%b exp=0", err); end
    checks++; if (err_code !== 2'd0) begin failures++; $display("FAIL rstmid_code got=%0d exp=0", err_code); end
    checks++; if (rx_wait !== 1'b1) begin failures++; $display("FAIL rstmid_idle got=%b exp=1", rx_wait); end
    drive_prefix(1'b0, m);
    rst_n = 1'b0;
    step(rand_jk(), 1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    checks++; if (bit_count !== '0) begin failures++; $display("FAIL rstmid_bc got=%0d exp=0", bit_count); end
    checks++; if (rx_wait !== 1'b1) begin failures++; $display("FAIL rstmid_idle2 got=%b exp=1", rx_wait); end
    step(SYM_J, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (obs !== 7'b0) begin failures++; $display("FAIL rstmid_pulses got=%b exp=0000000", obs); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; rx_req = 1'b0; rx_hs = 1'b0; abort = 1'b0; bus_in = SYM_J;
    test_reset();
    test_packet(1'b1, HSHAKE_BITS, 1'b0);
    test_packet(1'b0, 40, 1'b0);
    test_packet(1'b0, $urandom_range(1, DATA_BITS - 1), 1'b1);
    test_packet(1'b1, HSHAKE_BITS, 1'b1);
    test_overflow();
    test_broken_sync(4);
    test_broken_sync($urandom_range(1, SYNC_LEN - 1));
    test_timeout();
    test_conflict();
    test_bad_symbol();
    test_abort_over_done();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
